md_seq: RTL

- Multi-cycle multiply/divide sequencer beside the execute stage.
- Accepts a 16-bit MUL/DIV request from decode/execute control and stalls the pipeline while it iterates.
- Computes the result over 16 shift-add or restore-subtract steps, then returns it with a one-cycle done pulse.
- Flags divide-by-zero on err, matching the execute stage's error reporting.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_step.sv | 44 ++++
 rtl/md_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding and the divide-by-zero result value.
package md_pkg;

  localparam int MD_WIDTH = 16;

  typedef enum logic [1:0] {
    MD_MULL = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  localparam logic [MD_WIDTH-1:0] DIV0_RESULT = 16'hFFFF;

endpackage

// File: rtl/md_step.sv
// One iteration of the sequencer: shift-add multiply step or restoring
// divide step. acc holds {upper, lower} = {product hi, lo} or {rem, quot}.
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  md_op_e             i_op,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opa,
  input  logic [WIDTH-1:0]   i_opb,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_opa,
  output logic [WIDTH-1:0]   o_opb
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_acc    = i_acc;
    o_opa    = i_opa;
    o_opb    = i_opb;
    w_sum    = '0;
    w_rem_sh = '0;
    w_diff   = '0;
    if (!i_op[1]) begin
      // Multiplier bits are consumed LSB first; the carry becomes the new MSB.
      w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_opb[0] ? {1'b0, i_opa} : '0);
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
      o_opb = i_opb >> 1;
    end else begin
      // Dividend bits enter the remainder MSB first; diff[WIDTH] is the borrow.
      w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_opa[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, i_opb};
      o_opa    = i_opa << 1;
      if (!w_diff[WIDTH]) o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle unsigned multiply/divide sequencer beside the execute stage.
// Stalls the pipeline for WIDTH iterations and returns a one-cycle done pulse.
module md_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  md_state_e          w_state_next;
  md_op_e             r_op;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_err;

  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_opa_step;
  logic [WIDTH-1:0]   w_opb_step;
  logic               w_open;
  logic               w_accept;
  logic               w_div0;
  logic               w_last;
  logic [WIDTH-1:0]   w_final;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .i_opa (r_opa),
    .i_opb (r_opb),
    .o_acc (w_acc_step),
    .o_opa (w_opa_step),
    .o_opb (w_opb_step)
  );

  assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = w_open && start && !flush;
  assign w_div0   = op[1] && (srcB == '0);
  assign w_last   = (r_count == CW'(WIDTH - 1));
  // Odd op codes (MULH, REM) take the upper half of the accumulator.
  assign w_final  = r_op[0] ? w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[WIDTH-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_next = w_div0 ? ST_DONE : ST_RUN;
        else          w_state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (flush)       w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Stall is combinational so the requesting instruction holds in execute.
  assign stall  = (w_open && start) || (r_state == ST_RUN);
  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      r_op     <= MD_MULL;
      r_count  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= md_op_e'(op);
      r_opa   <= srcA;
      r_opb   <= srcB;
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= w_div0;
      if (w_div0) r_result <= WIDTH'(DIV0_RESULT);
    end else if (r_state == ST_RUN && !flush) begin
      r_acc   <= w_acc_step;
      r_opa   <= w_opa_step;
      r_opb   <= w_opb_step;
      r_count <= r_count + 1'b1;
      if (w_last) r_result <= w_final;
    end
  end

endmodule
